// File: rtl/rggen_irq_coalescer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rggen_irq_coalescer                                                      |
// | Interrupt coalescing in front of W0/1C status fields: forwards event     |
// | pulses to set inputs, raises one irq on a count threshold or a timeout,  |
// | holds it until all enabled status bits are cleared.                      |
// | Optional timeout path: define RGGEN_IRQ_COALESCER_TIMEOUT_EN             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rggen_irq_coalescer #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WIDTH-1:0]       i_event,
  input  logic [WIDTH-1:0]       i_enable,
  input  logic [WIDTH-1:0]       i_status,
  input  logic [COUNT_WIDTH-1:0] i_threshold,
  input  logic [TIMER_WIDTH-1:0] i_timeout,
  output logic [WIDTH-1:0]       o_set,
  output logic                   o_irq,
  output logic [COUNT_WIDTH-1:0] o_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ASSERT = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic [COUNT_WIDTH-1:0] threshold_eff;
  logic                   hit;
  logic                   threshold_hit;
  logic                   timeout_hit;
  logic                   clear_done;

  assign hit           = |(i_event & i_enable);
  assign threshold_eff = (i_threshold == '0) ? COUNT_ONE : i_threshold;
  assign count_inc     = (hit && (o_count != COUNT_MAX)) ? o_count + COUNT_ONE : o_count;
  // Compare one bit wider so a saturated count plus a hit still reaches the threshold.
  assign threshold_hit = ({1'b0, o_count} + (COUNT_WIDTH + 1)'(hit)) >= {1'b0, threshold_eff};
  // o_set and i_event cover the two cycles before a new event shows up on i_status.
  assign clear_done    = ((i_status | o_set | i_event) & i_enable) == '0;

`ifdef RGGEN_IRQ_COALESCER_TIMEOUT_EN
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = TIMER_WIDTH'(1);

  logic [TIMER_WIDTH-1:0] timer;
  logic [TIMER_WIDTH-1:0] timer_next;

  assign timeout_hit = (i_timeout != '0) && (timer == i_timeout);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer <= '0;
    end else begin
      timer <= timer_next;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^i_timeout;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    count_next = o_count;
`ifdef RGGEN_IRQ_COALESCER_TIMEOUT_EN
    timer_next = timer;
`endif
    case (state)
      IDLE: begin
        if (hit) begin
          count_next = COUNT_ONE;
`ifdef RGGEN_IRQ_COALESCER_TIMEOUT_EN
          timer_next = TIMER_ONE;
`endif
          state_next = (threshold_eff == COUNT_ONE) ? ASSERT : ACCUM;
        end
      end
      ACCUM: begin
        count_next = count_inc;
`ifdef RGGEN_IRQ_COALESCER_TIMEOUT_EN
        timer_next = (timer == TIMER_MAX) ? timer : timer + TIMER_ONE;
`endif
        if (threshold_hit || timeout_hit) begin
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (clear_done) begin
          state_next = IDLE;
          count_next = '0;
`ifdef RGGEN_IRQ_COALESCER_TIMEOUT_EN
          timer_next = '0;
`endif
        end else begin
          count_next = count_inc;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_set   <= '0;
      o_irq   <= 1'b0;
      o_count <= '0;
    end else begin
      state   <= state_next;
      o_set   <= i_event;
      o_irq   <= (state_next == ASSERT);
      o_count <= count_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rggen_irq_coalescer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rggen_irq_coalescer                                                   |
// | Randomized bench for rggen_irq_coalescer with a behavioural model and a  |
// | model of the external W0/1C status fields. Revision: 1.0                 |
// +--------------------------------------------------------------------------+
module tb_rggen_irq_coalescer;

`ifdef RGGEN_IRQ_COALESCER_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ev;
  logic [7:0]  en;
  logic [7:0]  st;
  logic [7:0]  thr;
  logic [15:0] to;
  logic [7:0]  clr;

  logic [7:0]  set_a;
  logic [7:0]  set_b;
  logic        irq_a;
  logic        irq_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 = no window, 1 = collecting, 2 = interrupt pending.
  int m_mode [2];
  int m_cnt  [2];
  int m_tmr  [2];
  int m_set;
  int cmax   [2] = '{255, 3};

  always #5 clk = ~clk;

  rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(8), .TIMER_WIDTH(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_event(ev), .i_enable(en), .i_status(st),
    .i_threshold(thr), .i_timeout(to), .o_set(set_a), .o_irq(irq_a), .o_count(cnt_a)
  );

  rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(2), .TIMER_WIDTH(16)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_event(ev), .i_enable(en), .i_status(st),
    .i_threshold(thr[1:0]), .i_timeout(to), .o_set(set_b), .o_irq(irq_b), .o_count(cnt_b)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance one clock: compute expected next values from the current inputs,
  // clock the DUTs, then compare.
  task automatic step();
    int hit;
    int te;
    int nmode [2];
    int ncnt  [2];
    int ntmr  [2];
    int nst;
    bit reach;
    bit tmo;
    hit = ((ev & en) != 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      te       = (k == 0) ? int'(thr) : int'(thr & 8'h03);
      if (te == 0) te = 1;
      nmode[k] = m_mode[k];
      ncnt[k]  = m_cnt[k];
      ntmr[k]  = m_tmr[k];
      if (rst) begin
        nmode[k] = 0;
        ncnt[k]  = 0;
        ntmr[k]  = 0;
      end else if (m_mode[k] == 0) begin
        if (hit == 1) begin
          ncnt[k]  = 1;
          ntmr[k]  = 1;
          nmode[k] = (te == 1) ? 2 : 1;
        end
      end else if (m_mode[k] == 1) begin
        tmo      = TIMEOUT_ON && (to != 0) && (m_tmr[k] == int'(to));
        reach    = (m_cnt[k] + hit) >= te;
        ncnt[k]  = imin(m_cnt[k] + hit, cmax[k]);
        ntmr[k]  = imin(m_tmr[k] + 1, 65535);
        if (reach || tmo) nmode[k] = 2;
      end else begin
        if (((int'(st) | m_set | int'(ev)) & int'(en)) == 0) begin
          nmode[k] = 0;
          ncnt[k]  = 0;
          ntmr[k]  = 0;
        end else begin
          ncnt[k] = imin(m_cnt[k] + hit, cmax[k]);
        end
      end
    end
    // External status field: set from o_set, software clear, set wins.
    nst = (int'(st) & ~int'(clr) | m_set) & 8'hFF;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = nmode[k];
      m_cnt[k]  = ncnt[k];
      m_tmr[k]  = ntmr[k];
    end
    m_set = rst ? 0 : int'(ev);
    st    = nst[7:0];
    check_value("set_a",   32'(set_a), m_set);
    check_value("irq_a",   32'(irq_a), (m_mode[0] == 2) ? 1 : 0);
    check_value("count_a", 32'(cnt_a), m_cnt[0]);
    check_value("set_b",   32'(set_b), m_set);
    check_value("irq_b",   32'(irq_b), (m_mode[1] == 2) ? 1 : 0);
    check_value("count_b", 32'(cnt_b), m_cnt[1]);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0;
      m_cnt[k]  = 0;
      m_tmr[k]  = 0;
    end
    m_set = 0;
    rst = 1'b1; ev = 8'h00; en = 8'hFF; st = 8'h00; clr = 8'h00;
    thr = 8'd3; to = 16'd0;
    step();
    step();
    rst = 1'b0;

    // Threshold-only window, then software clears the status.
    for (int c = 1; c <= 40; c++) begin
      ev  = (c == 10 || c == 15 || c == 20) ? 8'h01 : 8'h00;
      clr = (c > 30) ? st : 8'h00;
      step();
    end

    // Timeout window with a single event.
    thr = 8'd10; to = 16'd5; ev = 8'h00; clr = 8'h00;
    step();
    ev = 8'h04; step();
    ev = 8'h00;
    for (int c = 0; c < 10; c++) step();
    for (int c = 0; c < 6; c++) begin
      clr = st;
      step();
    end

    // Reset while collecting, then restart.
    thr = 8'd10; to = 16'd0; clr = 8'h00;
    ev = 8'h08; step();
    ev = 8'h08; step();
    ev = 8'h00; step(); step();
    rst = 1'b1; step();
    rst = 1'b0; ev = 8'h10; step();
    ev = 8'h00;
    for (int c = 0; c < 4; c++) step();

    // Randomized operation with a clearing software agent.
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        thr = 8'($urandom_range(0, 5));
        to  = 16'($urandom_range(0, 8));
        en  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      end
      ev  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      clr = ($urandom_range(0, 2) == 0) ? (st & 8'($urandom)) : 8'h00;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rggen_irq_coalescer.md
# rggen_irq_coalescer

Interrupt-coalescing controller that sits in front of a bank of write-0/1-to-clear status bit fields. It forwards raw event pulses to the bit fields' set inputs and asserts a single interrupt request once enough enabled events have accumulated or a timeout expires. It holds the request until software has cleared every enabled status bit through the register interface.

## Interface
- WIDTH, 8: number of event sources / status bits.
- COUNT_WIDTH, 8: width of the accumulated-event counter and the threshold.
- TIMER_WIDTH, 16: width of the coalescing timer and the timeout.

- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous and active-high, one clock.
- i_event  input  WIDTH  per-source event pulses; any bit high counts.
- i_enable  input  WIDTH  per-source interrupt enable, from a register field.
- i_status  input  WIDTH  current status bits, from the status fields' unmasked value.
- i_threshold  input  COUNT_WIDTH  event-cycle count that fires the interrupt; 0 is treated as 1.
- i_timeout  input  TIMER_WIDTH  cycles from first event to forced interrupt; 0 disables the timeout.
- o_set  output  WIDTH  registered copy of i_event, to the status fields' set input.
- o_irq  output  1  interrupt request, registered.
- o_count  output  COUNT_WIDTH  current accumulated count, registered.

## Operation
- Hit: a cycle in which (i_event & i_enable) != 0. Hits count per cycle, not per bit.
- Reset values: state IDLE; o_set = 0; o_irq = 0; o_count = 0; timer = 0.
- o_set:
  - o_set <= i_event every cycle, regardless of state or enable.
  - Disabled sources still set status bits but never count.
- FSM has three states: IDLE, ACCUM, ASSERT.
- IDLE:
  - On a hit, count <= 1 and timer <= 1.
  - If the effective threshold is 1, go to ASSERT; otherwise go to ACCUM.
- ACCUM:
  - On each hit, count <= count + 1, saturating at all-ones.
  - Timer increments every cycle and saturates.
  - Go to ASSERT when either condition holds:
    - count + hit >= effective threshold; or
    - timeout is nonzero and timer == i_timeout, evaluated before the increment.
- ASSERT:
  - o_irq = 1.
  - Hits still increment count (saturating). The timer is frozen.
  - Go to IDLE when the following are all zero in the same cycle:
    - i_status & i_enable;
    - o_set & i_enable;
    - i_event & i_enable.
  - On that transition count <= 0 and timer <= 0.
- A hit in the exit cycle blocks the exit. It is absorbed into the current interrupt and does not start a new window.
- Changing i_threshold or i_timeout mid-ACCUM takes effect on the next comparison.
- Dropping i_enable mid-ACCUM stops counting but not the timer.
- Reset mid-operation returns everything to reset values on the next edge. o_set is cleared, so an event in the reset cycle is lost.

## Timing
- o_set lags i_event by 1 cycle. Status becomes visible on i_status 2 cycles after the event, because the status field adds a 1-cycle register.
- Threshold path: if the hit that reaches the threshold is sampled at edge N, o_irq is high from edge N+1.
- Timeout path: if the first hit is sampled at edge N, o_irq rises after edge N+i_timeout (for example, edge N+1 when i_timeout=1), unless the threshold fires first.
- o_irq falls one cycle after the exit condition is first sampled true.
- The exit check includes o_set and i_event, so the 2-cycle status lag can never cause a spurious exit.

## Configuration
- RGGEN_IRQ_COALESCER_TIMEOUT_EN:
  - Defined: the timer and the timeout path are present as described.
  - Undefined: no timer logic. i_timeout is ignored, and ACCUM leaves only on the threshold.
  - All ports are present in both builds.

## Test plan
- Threshold only:
  - Setup: threshold=3, timeout=0, enable=0xFF.
  - Stimulus: single-cycle events 0x01 at cycles 10, 15, 20.
  - Required: o_count reaches 3; o_irq rises at edge 21; o_set mirrors each event 1 cycle later.
- Timeout:
  - Setup: threshold=10, timeout=5.
  - Stimulus: one event 0x04 sampled at edge 30.
  - Required: o_irq high from edge 35; o_count=1.
  - Without RGGEN_IRQ_COALESCER_TIMEOUT_EN, o_irq stays 0.
- Clear handshake:
  - Stimulus: while in ASSERT with i_status=0x05 and enable=0x05, drop i_status to 0x01 and then to 0x00.
  - Required: o_irq stays high through 0x01; o_irq falls 1 cycle after i_status=0; o_count returns to 0.
- Event during exit:
  - Stimulus: in the cycle i_status reaches 0, i_event=0x02 with enable=0x02.
  - Required: o_irq stays high and count increments; exit happens only after the new status bit is cleared.
- Masking, saturation and threshold 0:
  - Stimulus: events only on disabled bits.
  - Required: o_set follows the events, o_count stays 0, o_irq stays 0.
  - Stimulus: COUNT_WIDTH=2 with 6 hits in ASSERT.
  - Required: o_count saturates at 3.
  - Stimulus: threshold=0 with a single hit.
  - Required: o_irq asserts 1 cycle later.
- Reset mid-ACCUM:
  - Stimulus: assert i_rst for one cycle with count=2 and timer=3.
  - Required: next cycle all outputs are 0 and the state is IDLE; a subsequent hit restarts with count=1.
